// File: rtl/vga_tile_renderer_if.sv
// Board-memory read port shared by the tile renderer and the BMEM.
interface vga_tile_renderer_if;
  logic       bmem_re;
  logic [9:0] bmem_raddr;
  logic [3:0] bmem_rdata;

  modport master (
    output bmem_re,
    output bmem_raddr,
    input  bmem_rdata
  );

  modport slave (
    input  bmem_re,
    input  bmem_raddr,
    output bmem_rdata
  );
endinterface

// File: rtl/vga_tile_renderer.sv
// VGA tile renderer: BMEM read, palette/grid mapping and pixel-aligned
// sync/RGB outputs, three clocks behind the scan position.
`ifndef HACTIVE
`define HACTIVE 640
`endif
`ifndef HFULLSCAN
`define HFULLSCAN 800
`endif
`ifndef VACTIVE
`define VACTIVE 480
`endif
`ifndef VFULLSCAN
`define VFULLSCAN 525
`endif

module vga_tile_renderer #(
  parameter int HACTIVE     = `HACTIVE,
  parameter int HFULLSCAN   = `HFULLSCAN,
  parameter int VACTIVE     = `VACTIVE,
  parameter int VFULLSCAN   = `VFULLSCAN,
  parameter int HSYNC_START = 656,
  parameter int HSYNC_END   = 752,
  parameter int VSYNC_START = 490,
  parameter int VSYNC_END   = 492,
  parameter int BLOCK       = 20,
  parameter bit GRIDLINES   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          row,
  input  logic [9:0]          col,
  input  logic                re,
  input  logic [9:0]          raddr,
  input  logic                updateoutput,
  vga_tile_renderer_if.master bmem,
  output logic                hsync,
  output logic                vsync,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue
);

  typedef struct packed {
    logic       vld;
    logic       act;
    logic       upd;
    logic [9:0] row;
    logic [9:0] col;
  } pos_t;

  typedef enum logic {
    WAIT_FRAME,
    RUN
  } state_t;

  localparam logic [9:0] HACT  = 10'(HACTIVE);
  localparam logic [9:0] HLAST = 10'(HFULLSCAN - 1);
  localparam logic [9:0] VACT  = 10'(VACTIVE);
  localparam logic [9:0] VLAST = 10'(VFULLSCAN - 1);
  localparam logic [9:0] HSS   = 10'(HSYNC_START);
  localparam logic [9:0] HSE   = 10'(HSYNC_END);
  localparam logic [9:0] VSS   = 10'(VSYNC_START);
  localparam logic [9:0] VSE   = 10'(VSYNC_END);
  localparam logic [4:0] BLAST = 5'(BLOCK - 1);

  pos_t        s0_d;
  pos_t        s0_q;
  pos_t        s1_q;
  logic        issue;
  logic        rd_q;
  logic        oob_q;
  logic [3:0]  tile_d;
  logic [3:0]  tile_q;
  logic [4:0]  xoff_d;
  logic [4:0]  xoff_q;
  logic [4:0]  yoff_d;
  logic [4:0]  yoff_q;
  logic        grid;
  logic        start;
  logic        hsync_d;
  logic        hsync_q;
  logic        vsync_d;
  logic        vsync_q;
  logic [11:0] pal;
  logic [11:0] pix_d;
  logic [11:0] rgb_q;
  state_t      st_q;

  always_comb begin
    issue    = re && !reset && (raddr[9:5] < 5'd24);
    s0_d.vld = 1'b1;
    s0_d.act = (row < HACT) && (col < VACT);
    s0_d.upd = updateoutput;
    s0_d.row = row;
    s0_d.col = col;
  end

  assign bmem.bmem_re    = issue;
  assign bmem.bmem_raddr = reset ? 10'd0 : raddr;

  // Offsets advance with the position moving into S1, so they align with s1_q.
  always_comb begin
    tile_d = tile_q;
    if (rd_q) begin
      tile_d = bmem.bmem_rdata;
    end else if (oob_q) begin
      tile_d = 4'd0;
    end
    xoff_d = (xoff_q == BLAST) ? 5'd0 : xoff_q + 5'd1;
    if (s0_q.row == 10'd0) begin
      xoff_d = 5'd0;
    end
    yoff_d = yoff_q;
    if (s1_q.row == HLAST) begin
      yoff_d = (yoff_q == BLAST) ? 5'd0 : yoff_q + 5'd1;
      if (s0_q.col == 10'd0 || s1_q.col == VLAST) begin
        yoff_d = 5'd0;
      end
    end
  end

  always_comb begin
    grid = GRIDLINES && (xoff_q == 5'd0 || yoff_q == 5'd0);
    pal  = 12'hF0F;
    unique case (1'b1)
      tile_q == 4'd0 && grid:  pal = 12'h222;
      tile_q == 4'd0 && !grid: pal = 12'h000;
      tile_q == 4'd1:          pal = 12'h0F0;
      tile_q == 4'd2:          pal = 12'h0A0;
      tile_q == 4'd3:          pal = 12'hF00;
      tile_q == 4'd4:          pal = 12'h888;
      tile_q >= 4'd5:          pal = 12'hF0F;
    endcase
    pix_d = rgb_q;
    if (!s1_q.act) begin
      pix_d = 12'h000;
    end else if (s1_q.upd) begin
      pix_d = pal;
    end
    start = s1_q.vld && s1_q.row == 10'd0
            && s1_q.col == 10'd0;
    hsync_d = !(s1_q.vld && s1_q.row >= HSS
                && s1_q.row < HSE);
    vsync_d = !(s1_q.vld && s1_q.col >= VSS
                && s1_q.col < VSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q   <= '0;
      s1_q   <= '0;
      rd_q   <= 1'b0;
      oob_q  <= 1'b0;
      tile_q <= 4'd0;
      xoff_q <= 5'd0;
      yoff_q <= 5'd0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s0_q;
      rd_q   <= issue;
      oob_q  <= re && !issue;
      tile_q <= tile_d;
      xoff_q <= xoff_d;
      yoff_q <= yoff_d;
    end
  end

  // The frame-start pixel itself is already rendered.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= WAIT_FRAME;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      unique case (st_q)
        WAIT_FRAME: begin
          rgb_q <= start ? pix_d : 12'h000;
          if (start) begin
            st_q <= RUN;
          end
        end
        RUN: rgb_q <= pix_d;
      endcase
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: doc/vga_tile_renderer.md
# vga_tile_renderer

Downstream stage of the VGA controller. It consumes the controller's scan position (`row` horizontal, `col` vertical), board-memory read request (`re`, `raddr`) and `updateoutput` strobe. It performs the synchronous read of the 1k board BMEM, maps the returned tile code to a 12-bit colour with optional grid lines, and drives pixel-aligned `hsync`, `vsync` and RGB to the pins. All outputs are registered with fixed 3-cycle latency from the controller's `row`/`col`.

## Interface
- `HACTIVE`, default `` `HACTIVE `` (640): visible pixels per line.
- `HFULLSCAN`, default `` `HFULLSCAN `` (800): clocks per line.
- `VACTIVE`, default `` `VACTIVE `` (480): visible lines.
- `VFULLSCAN`, default `` `VFULLSCAN `` (525): lines per frame.
- `HSYNC_START`, default 656; `HSYNC_END`, default 752: hsync low for `HSYNC_START <= row < HSYNC_END`.
- `VSYNC_START`, default 490; `VSYNC_END`, default 492: vsync low for `VSYNC_START <= col < VSYNC_END`.
- `BLOCK`, default 20: pixels per tile edge.
- `GRIDLINES`, default 1: when 1, draw grid lines on tile pixel offset 0.
- `clk`, input, 1: pixel clock.
- `reset`, input, 1: synchronous, active-high.
- `row`, input, 10: horizontal position from the controller.
- `col`, input, 10: vertical position from the controller.
- `re`, input, 1: the controller requests a board read this cycle.
- `raddr`, input, 10: board address, `{tile_y[4:0], tile_x[4:0]}`.
- `updateoutput`, input, 1: when 1, the pixel colour may change this cycle.
- `bmem_re`, output, 1: BMEM read enable.
- `bmem_raddr`, output, 10: BMEM address.
- `bmem_rdata`, input, 4: tile code, valid the cycle after `bmem_re`.
- `hsync`, output, 1: active-low.
- `vsync`, output, 1: active-low.
- `red`, `green`, `blue`, output, 4 each: colour, forced to 0 outside the active area.

## Operation
**Stage 0 (S0).** Registers `row`, `col`, `updateoutput`, and `active = row<HACTIVE && col<VACTIVE`. It drives `bmem_re = re && raddr[9:5] < 24 && raddr[4:0] < 32` and `bmem_raddr = raddr` combinationally. Requests with an out-of-range address are dropped, and a flag `oob` is registered.

**Stage 1 (S1).** If the S0 read was issued, `tile <= bmem_rdata`. If the S0 read was dropped because of `oob`, `tile <= 0`. Otherwise `tile` holds its value. S1 also carries the S0 position and flags forward.

**In-tile offset counters.**
- `xoff` counts 0..BLOCK-1 on S1 `row`. It resets to 0 when `row==0`, and wraps to 0 after BLOCK-1.
- `yoff` counts 0..BLOCK-1 and increments when S1 `row==HFULLSCAN-1`. It resets when `col==0` at line end.

**Stage 2 (S2).** This stage registers the outputs.
- Sync: `hsync` and `vsync` are computed from the S1 position against the `*_START`/`*_END` parameters.
- Palette:
  - 0 → 000
  - 1 (body) → 0F0
  - 2 (head) → 0A0
  - 3 (food) → F00
  - 4 (wall) → 888
  - 5..15 → F0F (error magenta)
- Grid: if `GRIDLINES` and (`xoff==0 || yoff==0`) and `tile==0`, colour is 222.
- RGB load rule:
  - If not `active`, load 000.
  - If `active` and `updateoutput`, load the palette colour.
  - If `active` and not `updateoutput`, hold the previous value.

**Frame FSM.**
- `WAIT_FRAME`: entered on reset. RGB is forced to 000 and syncs are driven normally. Transition to `RUN` when S1 `row==0 && col==0`.
- `RUN`: normal operation. Return to `WAIT_FRAME` only on reset.

## Timing
- Reset values: `hsync=1`, `vsync=1`, RGB 000, `bmem_re=0` (combinational but gated by reset), `bmem_raddr=0`, `tile=0`, `xoff=yoff=0`, FSM in `WAIT_FRAME`, and all pipeline valid and active flags 0.
- Latency: `row`/`col` at cycle N appear as sync and RGB at cycle N+3. The BMEM read issued at N returns at N+1 and affects RGB at N+3.
- `re` with `updateoutput=0` in the same cycle: the tile is still captured, and the colour change waits for the next `updateoutput`.
- Row wrap (799→0) and col wrap (524→0): the sync decode has no glitch. `xoff` and `yoff` resynchronise at row 0 and col 0 regardless of drift.
- Reset mid-line: the next output cycle shows reset values. Pixels stay black until the first full frame start after reset.
- `bmem_rdata` is sampled only in the cycle following an issued read. It is ignored in all other cycles.

## Test plan
1. Hold reset for 5 cycles, then release and run 2 frames. Required: `hsync` and `vsync` are 1 during reset, RGB 000 until row=0/col=0 is seen. Then `hsync` is low for 96 clocks per 800, and `vsync` is low for 2 lines per 525.
2. BMEM model returns code 3 at address 0x021, with `re` pulsing at the tile starts. Required: RGB F00 at pixels x=20..39, y=20..39 (3 cycles late), except grid pixels x=20 or y=20, which are F00 because the tile is non-zero.
3. `updateoutput` held 0 for 10 cycles across a tile boundary from code 1 to code 2. Required: RGB stays 0F0 until `updateoutput=1`, then 0A0 on the following output cycle.
4. `raddr=0x3E0` (tile_y=31) with `re=1`. Required: `bmem_re=0`, the tile is treated as 0, and RGB is grid 222 or 000.
5. Reset asserted at row=300, col=100 for 1 cycle. Required: outputs go to reset values the next cycle, and RGB stays 000 until the next frame start.
6. Tile code 9. Required: RGB F0F.
